// File: rtl/arc4_pkg.sv
// Shared types and constants for the ARC4 decryption block.
package arc4_pkg;

  localparam int MEM_DEPTH = 256;
  localparam int KEY_LEN   = 3;

  localparam logic [6:0] HEX_BLANK = 7'h7F;

  typedef logic [7:0] byte_t;

  typedef enum logic [4:0] {
    IDLE,
    INIT,
    KSA_RD_I,
    KSA_WAIT_I,
    KSA_J,
    KSA_WAIT_J,
    KSA_WR_I,
    KSA_WR_J,
    PRGA_LEN_RD,
    PRGA_LEN_WAIT,
    PRGA_LEN,
    PRGA_RD_I,
    PRGA_WAIT_I,
    PRGA_J,
    PRGA_WAIT_J,
    PRGA_WR_I,
    PRGA_WR_J,
    PRGA_RD_PAD,
    PRGA_WAIT_PAD,
    PRGA_WR_PT,
    DONE
  } state_t;

  // Key byte selection: the 24-bit key is {14'b0, SW[9:0]}, big-endian bytes.
  function automatic byte_t key_byte(input logic [9:0] sw, input logic [1:0] idx);
    byte_t kb;
    case (idx)
      2'd0:    kb = 8'h00;
      2'd1:    kb = {6'b000000, sw[9:8]};
      2'd2:    kb = sw[7:0];
      default: kb = 8'h00;
    endcase
    return kb;
  endfunction

endpackage

// File: rtl/arc4_ram256x8.sv
// Single-port synchronous 256x8 RAM with registered read data.
module arc4_ram256x8
  import arc4_pkg::*;
(
  input  logic  clk,
  input  byte_t address,
  input  byte_t data,
  input  logic  wren,
  output byte_t q
);

  byte_t mem [0:MEM_DEPTH-1];

  // Synchronous write and one-cycle registered read (read returns old data on a write).
  always_ff @(posedge clk) begin
    if (wren) begin
      mem[address] <= data;
    end
    q <= mem[address];
  end

endmodule

// File: rtl/arc4_task3.sv
// ARC4 decryption top: builds the RC4 state in s, then decrypts the
// length-prefixed message in ct into pt, and raises LEDR[0] when finished.
module arc4_task3
  import arc4_pkg::*;
(
  input  logic       CLOCK_50,
  input  logic       rst,
  input  logic [3:0] KEY,
  input  logic [9:0] SW,
  output logic [6:0] HEX0,
  output logic [6:0] HEX1,
  output logic [6:0] HEX2,
  output logic [6:0] HEX3,
  output logic [6:0] HEX4,
  output logic [6:0] HEX5,
  output logic [9:0] LEDR
);

  state_t     state_r;
  byte_t      i_r;
  byte_t      j_r;
  byte_t      k_r;
  byte_t      len_r;
  byte_t      si_r;
  byte_t      sj_r;
  logic [1:0] kidx_r;
  logic       done_r;

  byte_t      s_addr_r;
  byte_t      s_wrdata_r;
  logic       s_wren_r;
  byte_t      s_q_s;

  byte_t      ct_addr_r;
  byte_t      ct_q_s;

  byte_t      pt_addr_r;
  byte_t      pt_wrdata_r;
  logic       pt_wren_r;
  byte_t      pt_q_s;

  byte_t      key_byte_s;
  logic       unused_s;

  // Push-buttons are reserved and pt is never read back by the block.
  assign unused_s = ^{KEY, pt_q_s};

  assign HEX0 = HEX_BLANK;
  assign HEX1 = HEX_BLANK;
  assign HEX2 = HEX_BLANK;
  assign HEX3 = HEX_BLANK;
  assign HEX4 = HEX_BLANK;
  assign HEX5 = HEX_BLANK;
  assign LEDR = {9'd0, done_r};

  // Select the key byte used by the current key-schedule step (i mod 3).
  always_comb begin
    key_byte_s = key_byte(SW, kidx_r);
  end

  arc4_ram256x8 s (
    .clk     (CLOCK_50),
    .address (s_addr_r),
    .data    (s_wrdata_r),
    .wren    (s_wren_r),
    .q       (s_q_s)
  );

  arc4_ram256x8 ct (
    .clk     (CLOCK_50),
    .address (ct_addr_r),
    .data    (8'h00),
    .wren    (1'b0),
    .q       (ct_q_s)
  );

  arc4_ram256x8 pt (
    .clk     (CLOCK_50),
    .address (pt_addr_r),
    .data    (pt_wrdata_r),
    .wren    (pt_wren_r),
    .q       (pt_q_s)
  );

  // Main sequencer: every memory read is issued, waited one cycle for the
  // RAM's registered output, and consumed in the following state.
  always_ff @(posedge CLOCK_50 or posedge rst) begin
    if (rst) begin
      state_r     <= IDLE;
      i_r         <= 8'd0;
      j_r         <= 8'd0;
      k_r         <= 8'd0;
      len_r       <= 8'd0;
      si_r        <= 8'd0;
      sj_r        <= 8'd0;
      kidx_r      <= 2'd0;
      done_r      <= 1'b0;
      s_addr_r    <= 8'd0;
      s_wrdata_r  <= 8'd0;
      s_wren_r    <= 1'b0;
      ct_addr_r   <= 8'd0;
      pt_addr_r   <= 8'd0;
      pt_wrdata_r <= 8'd0;
      pt_wren_r   <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          i_r       <= 8'd0;
          j_r       <= 8'd0;
          done_r    <= 1'b0;
          s_wren_r  <= 1'b0;
          pt_wren_r <= 1'b0;
          state_r   <= INIT;
        end
        INIT: begin
          s_addr_r   <= i_r;
          s_wrdata_r <= i_r;
          s_wren_r   <= 1'b1;
          i_r        <= i_r + 8'd1;
          if (i_r == 8'hFF) begin
            j_r     <= 8'd0;
            kidx_r  <= 2'd0;
            state_r <= KSA_RD_I;
          end
        end
        KSA_RD_I: begin
          s_wren_r <= 1'b0;
          s_addr_r <= i_r;
          state_r  <= KSA_WAIT_I;
        end
        KSA_WAIT_I: begin
          state_r <= KSA_J;
        end
        KSA_J: begin
          si_r     <= s_q_s;
          j_r      <= j_r + s_q_s + key_byte_s;
          s_addr_r <= j_r + s_q_s + key_byte_s;
          state_r  <= KSA_WAIT_J;
        end
        KSA_WAIT_J: begin
          state_r <= KSA_WR_I;
        end
        KSA_WR_I: begin
          sj_r       <= s_q_s;
          s_addr_r   <= i_r;
          s_wrdata_r <= s_q_s;
          s_wren_r   <= 1'b1;
          state_r    <= KSA_WR_J;
        end
        KSA_WR_J: begin
          // Second write of the swap lands after the first, so i==j is harmless.
          s_addr_r   <= j_r;
          s_wrdata_r <= si_r;
          s_wren_r   <= 1'b1;
          i_r        <= i_r + 8'd1;
          kidx_r     <= (kidx_r == 2'(KEY_LEN - 1)) ? 2'd0 : kidx_r + 2'd1;
          state_r    <= (i_r == 8'hFF) ? PRGA_LEN_RD : KSA_RD_I;
        end
        PRGA_LEN_RD: begin
          s_wren_r  <= 1'b0;
          i_r       <= 8'd0;
          j_r       <= 8'd0;
          ct_addr_r <= 8'd0;
          state_r   <= PRGA_LEN_WAIT;
        end
        PRGA_LEN_WAIT: begin
          state_r <= PRGA_LEN;
        end
        PRGA_LEN: begin
          len_r       <= ct_q_s;
          pt_addr_r   <= 8'd0;
          pt_wrdata_r <= ct_q_s;
          pt_wren_r   <= 1'b1;
          k_r         <= 8'd1;
          state_r     <= (ct_q_s == 8'd0) ? DONE : PRGA_RD_I;
        end
        PRGA_RD_I: begin
          pt_wren_r <= 1'b0;
          i_r       <= i_r + 8'd1;
          s_addr_r  <= i_r + 8'd1;
          state_r   <= PRGA_WAIT_I;
        end
        PRGA_WAIT_I: begin
          state_r <= PRGA_J;
        end
        PRGA_J: begin
          si_r     <= s_q_s;
          j_r      <= j_r + s_q_s;
          s_addr_r <= j_r + s_q_s;
          state_r  <= PRGA_WAIT_J;
        end
        PRGA_WAIT_J: begin
          state_r <= PRGA_WR_I;
        end
        PRGA_WR_I: begin
          sj_r       <= s_q_s;
          s_addr_r   <= i_r;
          s_wrdata_r <= s_q_s;
          s_wren_r   <= 1'b1;
          state_r    <= PRGA_WR_J;
        end
        PRGA_WR_J: begin
          s_addr_r   <= j_r;
          s_wrdata_r <= si_r;
          s_wren_r   <= 1'b1;
          state_r    <= PRGA_RD_PAD;
        end
        PRGA_RD_PAD: begin
          s_wren_r  <= 1'b0;
          s_addr_r  <= si_r + sj_r;
          ct_addr_r <= k_r;
          state_r   <= PRGA_WAIT_PAD;
        end
        PRGA_WAIT_PAD: begin
          state_r <= PRGA_WR_PT;
        end
        PRGA_WR_PT: begin
          pt_addr_r   <= k_r;
          pt_wrdata_r <= ct_q_s ^ s_q_s;
          pt_wren_r   <= 1'b1;
          k_r         <= k_r + 8'd1;
          state_r     <= (k_r == len_r) ? DONE : PRGA_RD_I;
        end
        DONE: begin
          s_wren_r  <= 1'b0;
          pt_wren_r <= 1'b0;
          done_r    <= 1'b1;
        end
        default: begin
          s_wren_r  <= 1'b0;
          pt_wren_r <= 1'b0;
          done_r    <= 1'b0;
          state_r   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_arc4_task3.sv
// Scoreboard bench for arc4_task3: expected pt contents come from a plain
// software RC4 model and are checked when the DUT raises LEDR[0].
module tb_arc4_task3;

  logic       CLOCK_50 = 1'b0;
  logic       rst;
  logic [3:0] KEY;
  logic [9:0] SW;
  logic [6:0] HEX0, HEX1, HEX2, HEX3, HEX4, HEX5;
  logic [9:0] LEDR;

  int n_checks = 0;
  int n_fail   = 0;

  always #10 CLOCK_50 = ~CLOCK_50;

  arc4_task3 dut (
    .CLOCK_50 (CLOCK_50),
    .rst      (rst),
    .KEY      (KEY),
    .SW       (SW),
    .HEX0     (HEX0),
    .HEX1     (HEX1),
    .HEX2     (HEX2),
    .HEX3     (HEX3),
    .HEX4     (HEX4),
    .HEX5     (HEX5),
    .LEDR     (LEDR)
  );

  typedef struct {
    int         run;
    int         addr;
    logic [7:0] val;
  } exp_t;

  exp_t       exp_q[$];
  int         run_id       = 0;
  int         runs_checked = 0;
  int         done_rises   = 0;
  int         bad_cycles   = 0;
  logic [7:0] cur_ct [256];

  task automatic chk(input string nm, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", nm, act, act, req, req);
    end
  endtask

  // Textbook RC4 with key bytes 00, {6'b0,sw[9:8]}, sw[7:0]; returns n keystream bytes.
  function automatic void rc4_ks(input logic [9:0] sw, input int n, output logic [7:0] ks [256]);
    int S[256];
    int K[3];
    int i, j, tmp;
    K[0] = 0;
    K[1] = int'(sw[9:8]);
    K[2] = int'(sw[7:0]);
    for (int a = 0; a < 256; a++) S[a] = a;
    j = 0;
    for (int a = 0; a < 256; a++) begin
      j = (j + S[a] + K[a % 3]) % 256;
      tmp = S[a]; S[a] = S[j]; S[j] = tmp;
    end
    i = 0;
    j = 0;
    for (int a = 0; a < 256; a++) ks[a] = 8'h00;
    for (int k = 0; k < n; k++) begin
      i = (i + 1) % 256;
      j = (j + S[i]) % 256;
      tmp = S[i]; S[i] = S[j]; S[j] = tmp;
      ks[k] = 8'(S[(S[i] + S[j]) % 256]);
    end
  endfunction

  // Blank displays and unused LEDs must hold through the whole simulation.
  always @(negedge CLOCK_50) begin
    if (HEX0 !== 7'h7F || HEX1 !== 7'h7F || HEX2 !== 7'h7F || HEX3 !== 7'h7F ||
        HEX4 !== 7'h7F || HEX5 !== 7'h7F || LEDR[9:1] !== 9'd0)
      bad_cycles++;
  end

  // Count every rise of the done indication.
  always @(posedge LEDR[0]) done_rises++;

  // Monitor: on each done rise, drain this run's expected entries and compare.
  initial begin
    exp_t e;
    int   ct_bad;
    forever begin
      @(posedge LEDR[0]);
      @(negedge CLOCK_50);
      while (exp_q.size() > 0 && exp_q[0].run == run_id) begin
        e = exp_q.pop_front();
        chk($sformatf("run%0d_pt[%0d]", run_id, e.addr), int'(dut.pt.mem[e.addr]), int'(e.val));
      end
      ct_bad = 0;
      for (int a = 0; a < 256; a++)
        if (dut.ct.mem[a] !== cur_ct[a]) ct_bad++;
      chk($sformatf("run%0d_ct_unchanged_bad_words", run_id), ct_bad, 0);
      runs_checked = run_id;
    end
  end

  task automatic do_run(input logic [9:0] sw, input int len, input bit zero_ct, input bit mid_reset);
    logic [7:0] ctv [256];
    logic [7:0] ptv [256];
    logic [7:0] ks  [256];
    int         cycles;
    exp_t       e;

    rst = 1'b1;
    SW  = sw;
    run_id++;
    exp_q.delete();
    for (int a = 0; a < 256; a++) begin
      ctv[a] = zero_ct ? 8'h00 : 8'($urandom);
      ptv[a] = 8'($urandom);
    end
    ctv[0] = 8'(len);
    for (int a = 0; a < 256; a++) begin
      dut.ct.mem[a] <= ctv[a];
      dut.pt.mem[a] <= ptv[a];
      cur_ct[a] = ctv[a];
    end
    @(negedge CLOCK_50);
    @(negedge CLOCK_50);
    chk($sformatf("run%0d_reset_LEDR", run_id), int'(LEDR), 0);
    chk($sformatf("run%0d_reset_HEX0", run_id), int'(HEX0), 'h7F);

    rc4_ks(sw, len, ks);
    e.run = run_id;
    e.addr = 0; e.val = 8'(len);
    exp_q.push_back(e);
    for (int k = 1; k <= len; k++) begin
      e.addr = k; e.val = ctv[k] ^ ks[k-1];
      exp_q.push_back(e);
    end
    if (len < 255) begin
      e.addr = len + 1; e.val = ptv[len + 1];
      exp_q.push_back(e);
    end

    done_rises = 0;
    rst = 1'b0;
    if (mid_reset) begin
      repeat (600) @(negedge CLOCK_50);
      rst = 1'b1;
      for (int c = 0; c < 3; c++) begin
        @(negedge CLOCK_50);
        chk($sformatf("run%0d_done_low_in_reset_c%0d", run_id, c), int'(LEDR[0]), 0);
      end
      rst = 1'b0;
    end

    cycles = 0;
    while (LEDR[0] !== 1'b1 && cycles < 6000) begin
      @(negedge CLOCK_50);
      cycles++;
    end
    chk($sformatf("run%0d_done_within_6000_cycles", run_id), int'(LEDR[0] === 1'b1), 1);

    for (int c = 0; c < 20 && runs_checked != run_id; c++) @(negedge CLOCK_50);
    chk($sformatf("run%0d_scoreboard_drained", run_id), runs_checked, run_id);

    repeat (50) @(negedge CLOCK_50);
    chk($sformatf("run%0d_done_held", run_id), int'(LEDR[0]), 1);
    chk($sformatf("run%0d_done_rises", run_id), done_rises, 1);
  endtask

  initial begin
    rst = 1'b1;
    KEY = 4'hF;
    SW  = 10'd0;
    repeat (2) @(negedge CLOCK_50);

    do_run(10'h155, $urandom_range(1, 254), 1'b0, 1'b0);
    do_run(10'($urandom), 0, 1'b0, 1'b0);
    do_run(10'h000, 255, 1'b1, 1'b0);
    do_run(10'($urandom), $urandom_range(1, 255), 1'b0, 1'b1);
    do_run(10'($urandom), $urandom_range(1, 255), 1'b0, 1'b0);

    chk("hex_blank_ledr_high_zero_bad_cycles", bad_cycles, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/arc4_task3.md
Name: arc4_task3

Overview:
- Top-level ARC4 (RC4) decryption block for the board.
- The 24-bit key is {14'b0, SW[9:0]}. The block decrypts a length-prefixed ciphertext held in on-chip memory `ct` and writes the length-prefixed plaintext to on-chip memory `pt`.
- A third memory `s` holds the RC4 state array.
- The block runs once after each reset release and then raises a done indication.

Parameters:
- KEY_LEN, 3, number of key bytes used cyclically by the key schedule.
- MEM_DEPTH, 256, depth of the s, ct and pt memories (8-bit words).

Ports:
- CLOCK_50  input  1  system clock; the only clock.
- rst  input  1  asynchronous, active-high reset.
- KEY  input  4  push-buttons; reserved and ignored.
- SW  input  10  key low bits; key bytes are K0=8'h00, K1={6'b0,SW[9:8]}, K2=SW[7:0].
- HEX0..HEX5  output  7 each  seven-segment outputs, active-low; held at 7'h7F (blank).
- LEDR  output  10  LEDR[0]=done; LEDR[9:1]=0.

Behaviour:
- Memories:
  - Three 256x8 single-port synchronous RAMs, instance names s, ct and pt.
  - Each has 1-cycle registered read latency and a synchronous write.
  - ct is preloaded externally before reset release. Its contents must remain hierarchically writable and are never written by the block.
  - pt contents are hierarchically readable.
- Reset:
  - While rst is high: FSM=IDLE, i=j=0, done=0, and all memory write enables deasserted.
  - HEX stays blank and LEDR=0.
- FSM states and transitions:
  - IDLE: entered one cycle after rst falls, then moves to INIT.
  - INIT: writes s[a]=a for a=0..255, one write per cycle (256 cycles), then goes to KSA.
  - KSA: for i=0..255:
    - read s[i];
    - j=(j+s[i]+K[i mod 3]) mod 256;
    - read s[j];
    - write s[i]=old s[j], then write s[j]=old s[i].
    - Writes are sequential, so i==j leaves the value unchanged.
  - PRGA setup: reset i=j=0, read len=ct[0], write pt[0]=len.
  - PRGA: for k=1..len:
    - i=(i+1) mod 256;
    - read si=s[i];
    - j=(j+si) mod 256;
    - read sj=s[j];
    - write s[i]=sj and s[j]=si;
    - read pad=s[(si+sj) mod 256] and ct[k];
    - write pt[k]=ct[k]^pad.
  - DONE: done=1, held until reset.
- Arithmetic: all index arithmetic is 8-bit with natural wrap-around; the key index wraps mod 3.
- Boundary cases:
  - len=0: only pt[0]=0 is written, then DONE.
  - len=255: writes pt[0..255].
  - pt locations beyond len are untouched.
- Latency: at most 6000 CLOCK_50 cycles from reset release to done=1 for any len (nominal budget about 256 + 6x256 + 9x255 cycles).
- Reset mid-operation: aborts immediately and restarts from IDLE on release. Partially written pt/s contents are not cleared but are overwritten by the rerun.
- SW is sampled continuously. SW must be stable from reset release to done; the result is undefined otherwise.

Decomposition:
- Package arc4_pkg:
  - state enum {IDLE, INIT, KSA_*, PRGA_*, DONE};
  - constants MEM_DEPTH=256 and KEY_LEN=3;
  - typedef byte_t (logic[7:0]).
- Sub-module arc4_ram256x8: single-port sync RAM with a `mem` array. It is instantiated three times as s, ct and pt.
- The FSM and datapath stay in the top level.

Test Plan:
- SW=10'h155, ct preloaded with a length-prefixed ciphertext: after reset release and 8000 cycles, pt[0..len] equals a software RC4 model with key 00 01 55 (pt[0]=ct[0], pt[k]=ct[k]^keystream[k-1]); LEDR[0]=1.
- ct[0]=0, SW arbitrary: done asserts; pt[0]=0; pt[1] unchanged from its prior value.
- SW=10'h000 (key 00 00 00), len=255, ct all 0: pt[1..255] equals the RC4 keystream for an all-zero 3-byte key.
- Assert rst for 3 cycles midway through KSA (about cycle 600), then release: the final pt matches the model; done=0 during reset; total time from final release is within 6000 cycles.
- During and after the run: HEX0..HEX5=7'h7F and LEDR[9:1]=0; LEDR[0] rises exactly once and stays high; ct contents are unchanged.
